// File: rtl/cacc_pkg.sv
// cacc_pkg: shared FSM encoding and width helpers for the complex accumulate-and-dump block.
`default_nettype none

package cacc_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Growth of log2(len) bits makes a full block of worst-case samples unable to overflow.
  function automatic int acc_width(input int din_w, input int len);
    return din_w + clog2(len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cacc_sat.sv
// cacc_sat: arithmetic shift then reduce to OUT_WIDTH; clamps when CACC_SAT_EN is defined, wraps otherwise.
`default_nettype none

module cacc_sat #(
  parameter int IN_WIDTH  = 21,
  parameter int OUT_WIDTH = 17,
  parameter int SHIFT     = 0
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat
);

`ifdef CACC_SAT_EN
  if (OUT_WIDTH >= IN_WIDTH) begin : g_wide
    assign dout = OUT_WIDTH'(din >>> SHIFT);
    assign sat  = 1'b0;
  end else begin : g_clamp
    localparam logic signed [OUT_WIDTH-1:0] C_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] C_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    logic signed [IN_WIDTH-1:0] shifted;
    logic [IN_WIDTH-OUT_WIDTH:0] hi;
    logic ovf;
    assign shifted = din >>> SHIFT;
    // Value fits only if every bit above the output sign bit copies it.
    assign hi   = shifted[IN_WIDTH-1:OUT_WIDTH-1];
    assign ovf  = !((&hi) || !(|hi));
    assign dout = ovf ? (shifted[IN_WIDTH-1] ? C_MIN : C_MAX) : shifted[OUT_WIDTH-1:0];
    assign sat  = ovf;
  end
`else
  if (1) begin : g_wrap
    assign dout = OUT_WIDTH'(din >>> SHIFT);
    assign sat  = 1'b0;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/complex_acc_dump.sv
// complex_acc_dump: accumulates ACC_LEN I/Q samples and dumps one scaled result per block (CACC_SAT_EN selects clamping).
`default_nettype none

module complex_acc_dump
  import cacc_pkg::*;
#(
  parameter int DIN_WIDTH  = 17,
  parameter int ACC_LEN    = 16,
  parameter int DOUT_WIDTH = 17,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         acc_clr,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic signed [DIN_WIDTH-1:0]  din_i,
  input  logic signed [DIN_WIDTH-1:0]  din_q,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic signed [DOUT_WIDTH-1:0] dout_i,
  output logic signed [DOUT_WIDTH-1:0] dout_q,
  output logic                         sat_flag
);

  localparam int ACC_WIDTH = acc_width(DIN_WIDTH, ACC_LEN);
  localparam int CNT_WIDTH = clog2(ACC_LEN);

  logic signed [ACC_WIDTH-1:0]  acc_i, acc_q, sum_i, sum_q;
  logic signed [DOUT_WIDTH-1:0] red_i, red_q;
  logic [CNT_WIDTH-1:0]         cnt;
  logic                         sat_i, sat_q, last, accept, done;
  state_t                       state;

  assign last       = (cnt == CNT_WIDTH'(ACC_LEN - 1));
  assign dout_valid = (state == FULL);
  // Only the block-completing sample can stall, and only behind an unread result.
  assign din_ready  = !rst_n || !(last && dout_valid && !dout_ready);
  assign accept     = din_valid && din_ready && !acc_clr;
  assign done       = accept && last;
  assign sum_i      = acc_i + ACC_WIDTH'(din_i);
  assign sum_q      = acc_q + ACC_WIDTH'(din_q);

  cacc_sat #(.IN_WIDTH(ACC_WIDTH), .OUT_WIDTH(DOUT_WIDTH), .SHIFT(SHIFT)) u_sat_i (
    .din(sum_i), .dout(red_i), .sat(sat_i)
  );

  cacc_sat #(.IN_WIDTH(ACC_WIDTH), .OUT_WIDTH(DOUT_WIDTH), .SHIFT(SHIFT)) u_sat_q (
    .din(sum_q), .dout(red_q), .sat(sat_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_i    <= '0;
      acc_q    <= '0;
      cnt      <= '0;
      state    <= EMPTY;
      dout_i   <= '0;
      dout_q   <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (acc_clr || done) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else if (accept) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt + 1'b1;
      end

      case (state)
        EMPTY:   if (done) state <= FULL;
        FULL:    if (!done && dout_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase

      if (done) begin
        dout_i   <= red_i;
        dout_q   <= red_q;
        sat_flag <= sat_i || sat_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/complex_acc_dump.md
COMPLEX_ACC_DUMP -- requirements
Module: complex_acc_dump

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 17, signed width of each I/Q input product (8+8+1 from the upstream complex multiplier).
REQ-002 SHALL have parameter ACC_LEN, default 16, samples per dump (power of two, >=2).
REQ-003 SHALL have parameter DOUT_WIDTH, default 17, signed width of each I/Q output.
REQ-004 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the sum before output.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port acc_clr, input, 1, synchronous abort of the block in progress.
REQ-008 SHALL have ports din_valid (input, 1), din_ready (output, 1), din_i (input, DIN_WIDTH, signed) and din_q (input, DIN_WIDTH, signed); upstream sample handshake.
REQ-009 SHALL have ports dout_valid (output, 1), dout_ready (input, 1), dout_i (output, DOUT_WIDTH, signed) and dout_q (output, DOUT_WIDTH, signed); result handshake.
REQ-010 SHALL have port sat_flag, output, 1, set when either output was saturated.

Function
REQ-011 SHALL use internal ACC_WIDTH = DIN_WIDTH + log2(ACC_LEN) for both accumulators; no internal overflow is possible.
REQ-012 SHALL accept a sample only on a cycle with din_valid && din_ready, adding sign-extended din_i/din_q to acc_i/acc_q and incrementing a sample counter 0..ACC_LEN-1.
REQ-013 SHALL, on accepting the sample at count ACC_LEN-1, load the output register on that edge with the scaled sum including that sample; dout_valid rises the next cycle (1-cycle latency); accumulators and counter restart at 0 on the same edge.
REQ-014 SHALL have a two-state output FSM: EMPTY (dout_valid=0) and FULL (dout_valid=1); EMPTY->FULL on block completion; FULL->EMPTY on dout_ready with no completion that cycle; FULL->FULL with new data when dout_ready and a completion coincide.
REQ-015 SHALL drive din_ready = !(count==ACC_LEN-1 && dout_valid && !dout_ready); non-final samples are never stalled.
REQ-016 SHALL hold dout_i, dout_q, sat_flag stable while dout_valid && !dout_ready.
REQ-017 SHALL compute each output as (acc >>> SHIFT), floor rounding, then reduce to DOUT_WIDTH per REQ-023/REQ-024.
REQ-018 SHALL, on acc_clr, zero accumulators and counter; acc_clr wins over a simultaneous sample (sample discarded, din_ready stays per REQ-015); a pending result is unaffected.
REQ-019 SHALL use two's-complement wrap for the sample counter; ACC_LEN samples always form exactly one dump.

Reset
REQ-020 SHALL, with rst_n low at a rising edge, clear accumulators, counter, FSM to EMPTY, dout_valid=0, dout_i=0, dout_q=0, sat_flag=0; a pending result is discarded.
REQ-021 SHALL drive din_ready=1 during and after reset.

Configuration
REQ-022 SHALL use macro CACC_SAT_EN to select output reduction.
REQ-023 SHALL, with CACC_SAT_EN defined, clamp each shifted value to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1] and set sat_flag for that result if either channel clamped.
REQ-024 SHALL, without CACC_SAT_EN, take the low DOUT_WIDTH bits (wrap) and tie sat_flag to 0.

Structure
REQ-025 SHALL place the FSM state encoding (EMPTY/FULL), a log2 constant function and the ACC_WIDTH derivation in shared package cacc_pkg.
REQ-026 SHALL implement shift-and-reduce in sub-module cacc_sat (params IN_WIDTH, OUT_WIDTH, SHIFT), instantiated once per channel, combinational.

Verification (defaults; SAT = CACC_SAT_EN defined)
REQ-027 SHALL check: 16 samples din_i=1000, din_q=-500, dout_ready=1 -> one cycle after 16th handshake dout_valid=1, dout_i=16000, dout_q=-8000, sat_flag=0.
REQ-028 SHALL check: 16 samples din_i=65535, din_q=-65536 -> SAT: dout_i=65535, dout_q=-65536, sat_flag=1; no SAT: dout_i=-16, dout_q=0, sat_flag=0.
REQ-029 SHALL check: dout_ready=0, continuous din_valid -> 31 samples accepted, din_ready=0 at 32nd; first result held; one-cycle dout_ready pulse -> 32nd accepted same cycle, second result appears next cycle.
REQ-030 SHALL check: 5 samples of 7, acc_clr simultaneous with a 6th sample, then 16 samples of 1 -> dout_i=16, dout_q per input.
REQ-031 SHALL check: rst_n low for 1 cycle after 10 samples or while FULL -> dout_valid=0, outputs 0; next 16 samples of 2 -> dout_i=32.
